// File: rtl/prim_dispatch_if.sv
// Request and engine signal bundle for prim_dispatch.
// The slave modport is the dispatcher's view; master is the front-end/engine side.
interface prim_dispatch_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0]           req_op;
    logic [1:0][2:0][9:0] req_x;
    logic [1:0][2:0][8:0] req_y;
    logic [1:0][3:0]      req_tag;

    logic                 eng_sel;
    logic [9:0]           eng_x1;
    logic [9:0]           eng_x2;
    logic [9:0]           eng_x3;
    logic [8:0]           eng_y1;
    logic [8:0]           eng_y2;
    logic [8:0]           eng_y3;
    logic                 eng_start;
    logic                 eng_done;

    logic                 cmd_done;
    logic                 cmd_err;
    logic                 cmd_src;
    logic [3:0]           cmd_tag;
    logic                 busy;
    logic [CW-1:0]        fifo_count;

    modport slave (
        input  req_valid, req_op, req_x, req_y, req_tag, eng_done,
        output req_ready, eng_sel, eng_x1, eng_x2, eng_x3, eng_y1, eng_y2, eng_y3,
               eng_start, cmd_done, cmd_err, cmd_src, cmd_tag, busy, fifo_count
    );

    modport master (
        output req_valid, req_op, req_x, req_y, req_tag, eng_done,
        input  req_ready, eng_sel, eng_x1, eng_x2, eng_x3, eng_y1, eng_y2, eng_y3,
               eng_start, cmd_done, cmd_err, cmd_src, cmd_tag, busy, fifo_count
    );
endinterface

// File: rtl/prim_dispatch.sv
// Two-requester draw-command scheduler: arbitrates into a command FIFO and sequences the shared raster engine.
// Define PRIM_DISPATCH_RR_EN for round-robin contention handling; otherwise requester 0 has fixed priority.
module prim_dispatch #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic           clk,
    input  logic           reset,
    prim_dispatch_if.slave bus_io
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam int          CW       = AW + 1;
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

    typedef struct packed {
        logic            src;
        logic            op;
        logic [2:0][9:0] x;
        logic [2:0][8:0] y;
        logic [3:0]      tag;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        DONE,
        ABORT
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   wd_q, wd_d;
    entry_t        mem_q [FIFO_DEPTH];
    entry_t        cur_q;
    entry_t        new_entry;
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q, count_d;
    logic          grant;
    logic          full;
    logic          push;
    logic          pop;
    logic          report;

`ifdef PRIM_DISPATCH_RR_EN
    logic rr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else if (push) begin
            rr_q <= ~grant;
        end
    end
`endif

    always_comb begin
        grant = 1'b0;
        if (bus_io.req_valid == 2'b11) begin
`ifdef PRIM_DISPATCH_RR_EN
            grant = rr_q;
`else
            grant = 1'b0;
`endif
        end else if (bus_io.req_valid[1]) begin
            grant = 1'b1;
        end
    end

    // Fullness comes from the registered count, so a pop never frees a slot within the same cycle.
    assign full             = (count_q == CW'(FIFO_DEPTH));
    assign bus_io.req_ready = (reset || full) ? 2'b00 : (grant ? 2'b10 : 2'b01);
    assign push             = |(bus_io.req_valid & bus_io.req_ready);
    assign pop              = (state_q == IDLE) && (count_q != '0);
    assign count_d          = count_q + CW'(push) - CW'(pop);

    always_comb begin
        new_entry.src = grant;
        new_entry.op  = bus_io.req_op[grant];
        new_entry.x   = bus_io.req_x[grant];
        new_entry.y   = bus_io.req_y[grant];
        new_entry.tag = bus_io.req_tag[grant];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            cur_q   <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q  <= rd_q + 1'b1;
                cur_q <= mem_q[rd_q];
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    // eng_done only counts while in WAIT; a level left over from the last command is ignored elsewhere.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                wd_d    = '0;
                state_d = START;
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + 16'd1;
                if (bus_io.eng_done) begin
                    state_d = DONE;
                end else if (wd_d == WD_LIMIT) begin
                    state_d = ABORT;
                end
            end
            DONE, ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign report            = (state_q == DONE) || (state_q == ABORT);
    assign bus_io.eng_sel    = cur_q.op;
    assign bus_io.eng_x1     = cur_q.x[0];
    assign bus_io.eng_x2     = cur_q.x[1];
    assign bus_io.eng_x3     = cur_q.op ? cur_q.x[2] : 10'd0;
    assign bus_io.eng_y1     = cur_q.y[0];
    assign bus_io.eng_y2     = cur_q.y[1];
    assign bus_io.eng_y3     = cur_q.op ? cur_q.y[2] : 9'd0;
    assign bus_io.eng_start  = (state_q == START);
    assign bus_io.cmd_done   = (state_q == DONE);
    assign bus_io.cmd_err    = (state_q == ABORT);
    assign bus_io.cmd_src    = report & cur_q.src;
    assign bus_io.cmd_tag    = report ? cur_q.tag : 4'd0;
    assign bus_io.busy       = (state_q != IDLE) || (count_q != '0);
    assign bus_io.fifo_count = count_q;
endmodule

// File: tb/tb_prim_dispatch.sv
// Randomized scoreboard bench for prim_dispatch: a queue-level model predicts accepts, engine starts and completions.
// Honours PRIM_DISPATCH_RR_EN when predicting contention winners.
module tb_prim_dispatch;
    localparam int DEPTH = 4;
    localparam int TMO   = 64;
    localparam int NEVER = 32'h3fff_ffff;

    typedef struct {
        bit src;
        bit op;
        int x1, x2, x3, y1, y2, y3;
        int tag;
        int mode;
        int delay;
    } cmd_t;

    typedef struct {
        bit src;
        int tag;
        bit err;
        int cyc;
    } comp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prim_dispatch_if #(.FIFO_DEPTH(DEPTH)) bus ();

    prim_dispatch #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus_io(bus)
    );

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    cmd_t  fifoQ[$];
    comp_t sbQ[$];
    cmd_t  pend[2];
    cmd_t  cur;
    bit    acc[2];
    bit    rrPref;
    bit    inFlight;
    bit    prevReset;
    bit    holdActive;
    int    startCycle, compCycle, freeAt;
    int    doneAt, holdFrom, holdTo;
    int    fullSeen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clearModel();
        fifoQ.delete();
        inFlight   = 1'b0;
        freeAt     = 0;
        rrPref     = 1'b0;
        doneAt     = -1;
        holdActive = 1'b0;
        startCycle = NEVER;
        compCycle  = NEVER;
        acc[0]     = 1'b0;
        acc[1]     = 1'b0;
    endtask

    // Engine behaviour is chosen per command: 0 pulse, 1 level held into the next command, 2 never finish.
    task automatic scheduleEngine(input int t);
        comp_t c;
        c.src = cur.src;
        c.tag = cur.tag;
        if (cur.mode == 2) begin
            c.err     = 1'b1;
            compCycle = t + TMO + 1;
        end else begin
            c.err     = 1'b0;
            doneAt    = t + cur.delay;
            compCycle = t + cur.delay + 1;
            if (cur.mode == 1) begin
                holdActive = 1'b1;
                holdFrom   = t + cur.delay;
                holdTo     = NEVER;
            end
        end
        c.cyc = compCycle;
        sbQ.push_back(c);
    endtask

    task automatic modelStep();
        int          t;
        bit          full, g, popNow;
        logic [1:0]  expReady;
        logic [57:0] expCoord, actCoord;
        t = cyc;
        checkOutput("fifo_count", 64'(bus.fifo_count), 64'(fifoQ.size()));
        checkOutput("busy", 64'(bus.busy), 64'(inFlight || fifoQ.size() > 0));
        full = (fifoQ.size() == DEPTH);
        if (full) fullSeen++;
        if (bus.req_valid == 2'b11) begin
`ifdef PRIM_DISPATCH_RR_EN
            g = rrPref;
`else
            g = 1'b0;
`endif
        end else begin
            g = bus.req_valid[1];
        end
        expReady = full ? 2'b00 : (g ? 2'b10 : 2'b01);
        checkOutput("req_ready", 64'(bus.req_ready), 64'(expReady));
        checkOutput("eng_start", 64'(bus.eng_start), 64'(inFlight && t == startCycle));
        if (inFlight && t >= startCycle && t < compCycle) begin
            expCoord = {cur.op, 10'(cur.x1), 10'(cur.x2), cur.op ? 10'(cur.x3) : 10'd0,
                        9'(cur.y1), 9'(cur.y2), cur.op ? 9'(cur.y3) : 9'd0};
            actCoord = {bus.eng_sel, bus.eng_x1, bus.eng_x2, bus.eng_x3,
                        bus.eng_y1, bus.eng_y2, bus.eng_y3};
            checkOutput("eng_coords", 64'(actCoord), 64'(expCoord));
        end
        if (inFlight && t == startCycle) scheduleEngine(t);
        popNow = !inFlight && t >= freeAt && fifoQ.size() > 0;
        if (!full && bus.req_valid[g]) begin
            cmd_t e;
            e     = pend[g];
            e.src = g;
            fifoQ.push_back(e);
            acc[g] = 1'b1;
            rrPref = !g;
        end
        if (popNow) begin
            cur        = fifoQ.pop_front();
            inFlight   = 1'b1;
            startCycle = t + 2;
            compCycle  = NEVER;
            if (holdActive) holdTo = t + 2;
        end
        if (inFlight && t == compCycle) begin
            inFlight = 1'b0;
            freeAt   = t + 1;
        end
    endtask

    // Reference model and reset-state checks, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            if (prevReset) begin
                checkOutput("rst_ready", 64'(bus.req_ready), 64'd0);
                checkOutput("rst_count", 64'(bus.fifo_count), 64'd0);
                checkOutput("rst_ctrl", 64'({bus.busy, bus.eng_start, bus.cmd_done, bus.cmd_err,
                                             bus.cmd_src, bus.eng_sel, bus.cmd_tag}), 64'd0);
                checkOutput("rst_coords", 64'({bus.eng_x1, bus.eng_x2, bus.eng_x3,
                                               bus.eng_y1, bus.eng_y2, bus.eng_y3}), 64'd0);
            end
            clearModel();
            prevReset = 1'b1;
        end else begin
            prevReset = 1'b0;
            modelStep();
        end
    end

    // Completion monitor: every done/err pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset) begin
            sbQ.delete();
        end else if (bus.cmd_done || bus.cmd_err) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_completion: got done=%0b err=%0b tag=%0d expected no pulse (cycle %0d)",
                         bus.cmd_done, bus.cmd_err, bus.cmd_tag, cyc);
            end else begin
                comp_t e;
                e = sbQ.pop_front();
                checkOutput("cmd_kind", 64'({bus.cmd_done, bus.cmd_err}), e.err ? 64'd1 : 64'd2);
                checkOutput("cmd_src", 64'(bus.cmd_src), 64'(e.src));
                checkOutput("cmd_tag", 64'(bus.cmd_tag), 64'(e.tag));
                checkOutput("cmd_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        bus.eng_done = (cyc == doneAt) || (holdActive && cyc >= holdFrom && cyc <= holdTo);
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                bus.req_valid[i] = 1'b0;
                acc[i] = 1'b0;
            end
        end
    endtask

    function automatic cmd_t makeCmd(input int op, input int x1, input int y1, input int x2, input int y2,
                                     input int x3, input int y3, input int tag, input int mode, input int delay);
        cmd_t c;
        c.src = 1'b0;
        c.op  = (op != 0);
        c.x1 = x1; c.y1 = y1; c.x2 = x2; c.y2 = y2; c.x3 = x3; c.y3 = y3;
        c.tag   = tag;
        c.mode  = mode;
        c.delay = delay;
        return c;
    endfunction

    function automatic cmd_t randCmd();
        int r;
        r = $urandom_range(0, 9);
        return makeCmd($urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 511),
                       $urandom_range(0, 1023), $urandom_range(0, 511), $urandom_range(0, 1023),
                       $urandom_range(0, 511), $urandom_range(0, 15),
                       (r == 0) ? 2 : ((r <= 3) ? 1 : 0), $urandom_range(1, TMO));
    endfunction

    task automatic applyStimulus(input int i, input cmd_t c);
        pend[i]          = c;
        bus.req_op[i]    = c.op;
        bus.req_x[i][0]  = 10'(c.x1);
        bus.req_x[i][1]  = 10'(c.x2);
        bus.req_x[i][2]  = 10'(c.x3);
        bus.req_y[i][0]  = 9'(c.y1);
        bus.req_y[i][1]  = 9'(c.y2);
        bus.req_y[i][2]  = 9'(c.y3);
        bus.req_tag[i]   = 4'(c.tag);
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic waitAccepted(input int i);
        for (int k = 0; k < 600; k++) begin
            if (!bus.req_valid[i]) break;
            nextCycle();
        end
        checkOutput("accept_timeout", 64'(bus.req_valid[i]), 64'd0);
    endtask

    task automatic sendSerial(input int i, input cmd_t c);
        applyStimulus(i, c);
        nextCycle();
        waitAccepted(i);
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            idle = !inFlight && fifoQ.size() == 0 && sbQ.size() == 0 && bus.req_valid == 2'b00;
            if (idle) break;
            nextCycle();
        end
        checkOutput("drain_timeout", 64'(idle), 64'd1);
    endtask

    initial begin
        int sent[2];
        reset         = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_op    = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_tag   = '0;
        fullSeen      = 0;
        prevReset     = 1'b0;
        holdFrom      = NEVER;
        holdTo        = NEVER;
        clearModel();
        repeat (3) nextCycle();
        reset = 1'b0;
        nextCycle();

        // Single line from requester 0, engine finishes 40 cycles after start; x3/y3 junk must read back as 0.
        sendSerial(0, makeCmd(0, 10, 20, 50, 20, 777, 300, 3, 0, 40));
        waitIdle();

        // Both requesters valid continuously, eight commands each.
        sent[0] = 0;
        sent[1] = 0;
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!bus.req_valid[i] && sent[i] < 8) begin
                    applyStimulus(i, makeCmd($urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 511),
                                             $urandom_range(0, 1023), $urandom_range(0, 511), $urandom_range(0, 1023),
                                             $urandom_range(0, 511), 8 * i + sent[i], 0, 3));
                    sent[i]++;
                end
            end
            if (sent[0] == 8 && sent[1] == 8 && bus.req_valid == 2'b00) break;
            nextCycle();
        end
        waitIdle();

        // Slow engine: requester 1 overfills the FIFO and order must survive pointer wrap.
        for (int n = 0; n < 7; n++) begin
            if (!bus.req_valid[1]) applyStimulus(1, makeCmd(1, n, n + 1, n + 2, n + 3, n + 4, n + 5, n, 0, 30));
            nextCycle();
            waitAccepted(1);
        end
        waitIdle();

        // Timeout followed by a normal command, then held done levels spanning command boundaries.
        sendSerial(0, makeCmd(1, 100, 200, 300, 400, 500, 100, 9, 2, 1));
        sendSerial(0, makeCmd(0, 1, 2, 3, 4, 5, 6, 10, 0, 5));
        sendSerial(1, makeCmd(1, 7, 8, 9, 10, 11, 12, 11, 1, 4));
        sendSerial(0, makeCmd(0, 13, 14, 15, 16, 17, 18, 12, 1, 6));
        sendSerial(1, makeCmd(1, 19, 20, 21, 22, 23, 24, 13, 0, 2));
        waitIdle();

        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) applyStimulus(i, randCmd());
            end
            nextCycle();
        end
        waitIdle();

        // Reset while the engine is waiting with two commands still queued.
        sendSerial(0, makeCmd(1, 1, 1, 1, 1, 1, 1, 5, 2, 1));
        sendSerial(0, makeCmd(1, 2, 2, 2, 2, 2, 2, 6, 2, 1));
        sendSerial(0, makeCmd(1, 3, 3, 3, 3, 3, 3, 7, 2, 1));
        for (int k = 0; k < 200; k++) begin
            if (inFlight && cyc > startCycle && fifoQ.size() == 2) break;
            nextCycle();
        end
        checkOutput("wait_with_two_queued", 64'(inFlight && fifoQ.size() == 2), 64'd1);
        reset         = 1'b1;
        bus.req_valid = 2'b00;
        nextCycle();
        nextCycle();
        reset = 1'b0;
        repeat (100) nextCycle();

        sendSerial(1, makeCmd(0, 40, 41, 42, 43, 44, 45, 14, 0, 7));
        waitIdle();

        checkOutput("fifo_full_seen", 64'(fullSeen > 0), 64'd1);
        checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prim_dispatch.md
# prim_dispatch

Command scheduler for the rasterizer engines. Accepts line and filled-triangle draw commands from two requesters, arbitrates between them into a small command FIFO, and sequences the shared raster engine: presents coordinates, pulses start, waits for finish, and reports completion or timeout. It sits between the drawing front-ends and the line/triangle rasterizer pair, which share one pixel output path.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `TIMEOUT`, 65535: max cycles in WAIT before abort (16-bit counter).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  2  per-requester command valid.
- `req_ready`  out  2  per-requester accept; handshake when valid&ready.
- `req_op`  in  2×1  0=line (uses x1,y1,x2,y2), 1=triangle.
- `req_x`  in  2×3×10  x1,x2,x3 per requester, unsigned.
- `req_y`  in  2×3×9  y1,y2,y3 per requester, unsigned.
- `req_tag`  in  2×4  opaque command tag.
- `eng_sel`  out  1  0=line engine, 1=triangle engine.
- `eng_x1..eng_x3`  out  10 each  coordinates, held stable START through WAIT.
- `eng_y1..eng_y3`  out  9 each.
- `eng_start`  out  1  one-cycle start pulse.
- `eng_done`  in  1  engine finish level/pulse.
- `cmd_done`  out  1  one-cycle completion pulse.
- `cmd_err`  out  1  one-cycle timeout pulse.
- `cmd_src`  out  1  requester of completed/aborted command.
- `cmd_tag`  out  4  tag of completed/aborted command.
- `busy`  out  1  FSM not IDLE or FIFO non-empty.
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  occupied entries.

## Operation
- Arbitration: at most one accept per cycle. `req_ready[i]` = FIFO not full AND grant==i. Grant to sole valid requester; on both valid, per Configuration. Accepted entry stores {src, op, x1..3, y1..3, tag}.
- FIFO: circular, wrap-around pointers. Full determined from registered count at cycle start; no same-cycle push-on-pop when full. Pop only in IDLE when non-empty.
- FSM states:
  - IDLE: if FIFO non-empty, pop head → LOAD.
  - LOAD: register entry onto eng_* outputs, clear watchdog → START.
  - START: `eng_start`=1 for this cycle only → WAIT.
  - WAIT: increment watchdog; on `eng_done`=1 → DONE; else if watchdog==TIMEOUT → ABORT.
  - DONE: `cmd_done`=1, `cmd_src`/`cmd_tag` from current command → IDLE.
  - ABORT: `cmd_err`=1, `cmd_src`/`cmd_tag` valid → IDLE.
- `eng_done` ignored outside WAIT (a level held from the previous command does not complete the next; it is sampled only from the cycle after START).
- For line ops `eng_x3`/`eng_y3` driven 0.
- Coordinates pass unmodified; no clipping or sorting (engines sort vertices).

## Timing
- Reset: all outputs 0, FIFO empty, FSM IDLE, watchdog 0, RR pointer to requester 0. Reset mid-WAIT abandons the command with no `cmd_done`/`cmd_err`.
- Accept at edge N → entry counted at N+1 → pop into LOAD at N+1 (if IDLE) → `eng_start` high in cycle N+3.
- `eng_done` seen in WAIT cycle M → `cmd_done` high cycle M+1 → next command's `eng_start` no earlier than M+4.
- Accept and pop in the same cycle: count unchanged.
- Watchdog: `cmd_err` fires TIMEOUT+1 cycles after `eng_start`.

## Configuration
- `PRIM_DISPATCH_RR_EN` defined: round-robin; on contention grant the requester not granted most recently; pointer updates only on accepted handshake.
- Undefined: fixed priority, requester 0 always wins contention.

## Test plan
- Single line from req 0 (10,20)-(50,20), tag 3; engine asserts done 40 cycles after start → `eng_sel`=0, one `eng_start` pulse, `cmd_done` with src 0, tag 3.
- Both requesters valid continuously, 8 commands each, RR_EN defined → grants alternate 0,1,0,1; undefined → all req 0 first.
- Fill FIFO with 4 commands while engine stalled → `req_ready`=00, `fifo_count`=4; release done → one slot frees, ready reasserts, order preserved across pointer wrap.
- TIMEOUT=16, engine never asserts done → `cmd_err` 17 cycles after start with correct tag, next command starts.
- `eng_done` held high into next command → not treated as completion; only WAIT-cycle sampling completes.
- Assert `reset` during WAIT with 2 queued → all outputs 0, FIFO empty, no done/err pulses.
